rf_riscv_mp: RTL and testbench
==============================

Name: rf_riscv_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write/dual-read RV32 register file. It provides configurable data width, register count, read-port count and write-port count. Each read port has an optional same-cycle write-to-read bypass, and writes to the same register on the same cycle are resolved by fixed priority. An optional busy-bit scoreboard supports a dual-issue core. The block sits in the decode/writeback stages: decode uses the read ports and writeback uses the write ports.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers, 2..32; register 0 is hardwired zero
NRD, 2, number of read ports, 1..4
NWR, 1, number of write ports, 1..2
BYPASS, 1, 1 = a write in the current cycle is forwarded to a matching read; 0 = a read returns the stored value only
AW, 5, address width; must satisfy 2**AW >= NREGS

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous active-low reset
read_addr_i  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
read_data_o  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
write_enable_i  in  NWR  per-port write enable
write_addr_i  in  NWR*AW  write addresses, packed the same way as read addresses
write_data_i  in  NWR*XLEN  write data, packed the same way as read data
issue_valid_i  in  NWR  (RF_SCOREBOARD_EN only) marks the destination register busy
issue_addr_i  in  NWR*AW  (RF_SCOREBOARD_EN only) destination address to mark busy
busy_o  out  NRD  (RF_SCOREBOARD_EN only) busy flag of the register addressed by each read port

Behaviour:
- Reset: while rst_ni=0, asynchronously clear all registers to 0 and, with the scoreboard, clear all busy bits. Outputs while in reset:
  - read_data_o = 0
  - busy_o = 0
- Storage: NREGS-1 XLEN-wide flops. Register 0 has no storage.
- Write timing: on a rising clock edge with write_enable_i[j]=1 and 0 < write_addr[j] < NREGS, register[write_addr[j]] takes write_data[j]. The new value is visible as the stored value from the next cycle.
- Write suppression: a write to address 0, or to an address >= NREGS, is silently dropped.
- Write collision: if NWR=2 and both ports write the same valid address, port 1 wins and port 0's data is discarded.
- Reads: combinational, zero latency.
  - Address 0 returns 0.
  - An address >= NREGS returns 0.
- Bypass (BYPASS=1): if any enabled write port targets the same valid nonzero address as a read port in the same cycle, that read returns write_data, using the same port-1-wins priority. With BYPASS=0 the read returns the pre-edge stored value.
- No combinational path from write_data_i to read_data_o exists when BYPASS=0.
- Reset released mid-operation: the first rising edge after rst_ni deasserts performs normal writes. No writes are retained from the reset period.

Optional Feature:
Macro RF_SCOREBOARD_EN.
- Defined:
  - Adds issue_valid_i, issue_addr_i and busy_o.
  - Adds NREGS-1 busy flops.
  - Busy-bit rules, per register r, evaluated at the rising edge:
    - set if any issue_valid_i[j] targets r
    - else cleared if any write_enable_i[j] targets r
    - else held
  - An issue and a writeback to the same register on the same edge leave it busy, because the new producer wins.
  - busy_o[k] is combinational from the busy bits: 1 if the register at read_addr[k] is busy, 0 for address 0 or an address >= NREGS.
  - busy_o is not bypassed; the bench observes the flop value.
- Undefined:
  - Ports issue_valid_i, issue_addr_i and busy_o do not exist.
  - No busy flops are built.
  - Behaviour is otherwise identical.

Test Plan:
1. Reset and x0: assert rst_ni=0 mid-run after writing x5=0xDEADBEEF; then release reset and write x0=0x1234. Required: both ports read x5=0 during reset and after release; x0 reads 0 in the write cycle and every later cycle.
2. Basic write/read: write x1=0xA5A5A5A5, then x31=0xFFFFFFFF on consecutive cycles. Required: next cycle, port0 reads x1=0xA5A5A5A5 and port1 reads x31=0xFFFFFFFF.
3. Bypass: write x7=0x11 in cycle 0, then write x7=0x22 in cycle 1 while port0 reads x7.
   - BYPASS=1: port0 reads 0x22 in cycle 1.
   - BYPASS=0: port0 reads 0x11 in cycle 1 and 0x22 in cycle 2.
4. Write collision (NWR=2): port0 writes x3=0x100 and port1 writes x3=0x200 on the same edge. Required: x3 reads 0x200; with BYPASS=1 the same-cycle read also returns 0x200.
5. Out-of-range (NREGS=16): write x20=0x55. Required: the write is dropped and a read of x20 returns 0; also confirm x4 is unaffected, i.e. there is no address aliasing.
6. Scoreboard (RF_SCOREBOARD_EN): issue x9 in cycle 0, giving busy_o=1 in cycle 1; writeback x9 in cycle 2, giving busy_o=0 in cycle 3. Then issue and writeback x9 on the same edge; required: busy_o stays 1.

Source files
------------

// File: rtl/rf_riscv_mp.sv
// Parametrised multi-port integer register file; x0 reads as zero and has no storage.
// Define RF_SCOREBOARD_EN to add per-register busy bits for a dual-issue core.
module rf_riscv_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NRD*AW-1:0]   read_addr_i,
  input  logic [NWR-1:0]      write_enable_i,
  input  logic [NWR*AW-1:0]   write_addr_i,
  input  logic [NWR*XLEN-1:0] write_data_i,
`ifdef RF_SCOREBOARD_EN
  input  logic [NWR-1:0]      issue_valid_i,
  input  logic [NWR*AW-1:0]   issue_addr_i,
  output logic [NRD-1:0]      busy_o,
`endif
  output logic [NRD*XLEN-1:0] read_data_o
);

  localparam logic [31:0] NREGS_U = 32'(NREGS);

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREGS_U);
  endfunction

  logic [XLEN-1:0] regs_q [1:NREGS-1];

  // Per-register write select; later ports override earlier ones so port 1 wins a collision.
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [XLEN-1:0] reg_d;

    always_comb begin
      reg_d = regs_q[gi];
      for (int j = 0; j < NWR; j++) begin
        if (write_enable_i[j] && (write_addr_i[j*AW +: AW] == AW'(gi))) begin
          reg_d = write_data_i[j*XLEN +: XLEN];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= reg_d;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] stored;
    logic [XLEN-1:0] rd;

    assign ra = read_addr_i[gi*AW +: AW];

    // Only addresses 1..NREGS-1 match, so x0 and out-of-range reads fall through to zero.
    always_comb begin
      stored = '0;
      for (int r = 1; r < NREGS; r++) begin
        if (ra == AW'(r)) begin
          stored = regs_q[r];
        end
      end
    end

    if (BYPASS != 0) begin : g_byp
      // Forwarding is suppressed in reset so the port reads zero throughout.
      always_comb begin
        rd = stored;
        if (rst_ni && addr_ok(ra)) begin
          for (int j = 0; j < NWR; j++) begin
            if (write_enable_i[j] && (write_addr_i[j*AW +: AW] == ra)) begin
              rd = write_data_i[j*XLEN +: XLEN];
            end
          end
        end
      end
    end else begin : g_nobyp
      assign rd = stored;
    end

    assign read_data_o[gi*XLEN +: XLEN] = rd;
  end

`ifdef RF_SCOREBOARD_EN
  logic busy_q [1:NREGS-1];

  // A new issue outranks a writeback on the same edge: the newer producer owns the register.
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    logic iss_hit;
    logic wb_hit;

    always_comb begin
      iss_hit = 1'b0;
      wb_hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (issue_valid_i[j] && (issue_addr_i[j*AW +: AW] == AW'(gi))) begin
          iss_hit = 1'b1;
        end
        if (write_enable_i[j] && (write_addr_i[j*AW +: AW] == AW'(gi))) begin
          wb_hit = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        busy_q[gi] <= 1'b0;
      end else if (iss_hit) begin
        busy_q[gi] <= 1'b1;
      end else if (wb_hit) begin
        busy_q[gi] <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_busy_rd
    always_comb begin
      busy_o[gi] = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (read_addr_i[gi*AW +: AW] == AW'(r)) begin
          busy_o[gi] = busy_q[r];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Bench for rf_riscv_mp: three configurations (32x1W bypass, 16x2W no-bypass, 16x2W bypass)
// driven in parallel and checked against directed constants and an array-based model.
module tb_rf_riscv_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] rd_a, rd_b, rd_c;
`ifdef RF_SCOREBOARD_EN
  logic [1:0]  iv;
  logic [9:0]  iaddr;
  logic [1:0]  busy_a, busy_b, busy_c;
`endif

  int tests = 0;
  int fails = 0;

  rf_riscv_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(1), .AW(5)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .read_addr_i(raddr),
    .write_enable_i(we[0:0]), .write_addr_i(waddr[4:0]), .write_data_i(wdata[31:0]),
`ifdef RF_SCOREBOARD_EN
    .issue_valid_i(iv[0:0]), .issue_addr_i(iaddr[4:0]), .busy_o(busy_a),
`endif
    .read_data_o(rd_a)
  );

  rf_riscv_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(2), .BYPASS(0), .AW(5)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .read_addr_i(raddr),
    .write_enable_i(we), .write_addr_i(waddr), .write_data_i(wdata),
`ifdef RF_SCOREBOARD_EN
    .issue_valid_i(iv), .issue_addr_i(iaddr), .busy_o(busy_b),
`endif
    .read_data_o(rd_b)
  );

  rf_riscv_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(2), .BYPASS(1), .AW(5)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .read_addr_i(raddr),
    .write_enable_i(we), .write_addr_i(waddr), .write_data_i(wdata),
`ifdef RF_SCOREBOARD_EN
    .issue_valid_i(iv), .issue_addr_i(iaddr), .busy_o(busy_c),
`endif
    .read_data_o(rd_c)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_rf   [3][32];
  logic        m_busy [3][32];

  function automatic int nregs_of(int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic int nwr_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit byp_of(int i);
    return i != 1;
  endfunction

  function automatic logic [31:0] act_rd(int i, int k);
    logic [63:0] v;
    v = (i == 0) ? rd_a : ((i == 1) ? rd_b : rd_c);
    return v[k*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_rd(int i, int k);
    int a;
    logic [31:0] v;
    a = int'(raddr[k*5 +: 5]);
    if (!rst_n || a == 0 || a >= nregs_of(i)) return '0;
    v = m_rf[i][a];
    if (byp_of(i)) begin
      for (int j = 0; j < nwr_of(i); j++) begin
        if (we[j] && int'(waddr[j*5 +: 5]) == a) v = wdata[j*32 +: 32];
      end
    end
    return v;
  endfunction

`ifdef RF_SCOREBOARD_EN
  function automatic logic [1:0] act_busy(int i);
    return (i == 0) ? busy_a : ((i == 1) ? busy_b : busy_c);
  endfunction

  function automatic logic exp_busy(int i, int k);
    int a;
    a = int'(raddr[k*5 +: 5]);
    if (!rst_n || a == 0 || a >= nregs_of(i)) return 1'b0;
    return m_busy[i][a];
  endfunction
`endif

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 32; r++) begin
        m_rf[i][r]   = '0;
        m_busy[i][r] = 1'b0;
      end
    end
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
`ifdef RF_SCOREBOARD_EN
        for (int r = 1; r < nregs_of(i); r++) begin
          bit s;
          bit c;
          s = 1'b0;
          c = 1'b0;
          for (int j = 0; j < nwr_of(i); j++) begin
            if (iv[j] && int'(iaddr[j*5 +: 5]) == r) s = 1'b1;
            if (we[j] && int'(waddr[j*5 +: 5]) == r) c = 1'b1;
          end
          if (s) m_busy[i][r] = 1'b1;
          else if (c) m_busy[i][r] = 1'b0;
        end
`endif
        for (int j = 0; j < nwr_of(i); j++) begin
          int a;
          a = int'(waddr[j*5 +: 5]);
          if (we[j] && a != 0 && a < nregs_of(i)) m_rf[i][a] = wdata[j*32 +: 32];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic idle();
    we    = '0;
    waddr = '0;
    wdata = '0;
`ifdef RF_SCOREBOARD_EN
    iv    = '0;
    iaddr = '0;
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    raddr = {5'd6, 5'd5};
    idle();
    #1;
    rst_n = 1'b0;
    model_reset();
    we    = 2'b11;
    waddr = {5'd6, 5'd5};
    wdata = {32'h66, 32'h55};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (act_rd(i, k) !== 32'h0) begin
            fails++;
            $display("FAIL reset_hold inst%0d port%0d cyc%0d: got %h want 0", i, k, c, act_rd(i, k));
          end
        end
      end
      tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 0) !== 32'h0) begin
        fails++;
        $display("FAIL reset_no_retain inst%0d: got %h want 0", i, act_rd(i, 0));
      end
    end

    // x5 written, then reset asserted mid-cycle, then x0 written on release.
    tick();
    we    = 2'b01;
    waddr = {5'd0, 5'd5};
    wdata = {32'h0, 32'hDEADBEEF};
    tick();
    idle();
    raddr = {5'd5, 5'd5};
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (act_rd(0, k) !== 32'hDEADBEEF) begin
        fails++;
        $display("FAIL x5_before_reset port%0d: got %h want deadbeef", k, act_rd(0, k));
      end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act_rd(i, k) !== 32'h0) begin
          fails++;
          $display("FAIL async_reset inst%0d port%0d: got %h want 0", i, k, act_rd(i, k));
        end
      end
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    we    = 2'b01;
    waddr = {5'd0, 5'd0};
    wdata = {32'h0, 32'h1234};
    raddr = {5'd5, 5'd0};
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (act_rd(i, k) !== 32'h0) begin
            fails++;
            $display("FAIL x0_x5_after_release inst%0d port%0d cyc%0d: got %h want 0", i, k, c, act_rd(i, k));
          end
        end
      end
      tick();
      idle();
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    logic [31:0] want1 [3];
    tick();
    we    = 2'b01;
    waddr = {5'd0, 5'd1};
    wdata = {32'h0, 32'hA5A5A5A5};
    tick();
    waddr = {5'd0, 5'd31};
    wdata = {32'h0, 32'hFFFFFFFF};
    tick();
    idle();
    raddr = {5'd31, 5'd1};
    want1 = '{32'hFFFFFFFF, 32'h0, 32'h0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 0) !== 32'hA5A5A5A5) begin
        fails++;
        $display("FAIL basic_x1 inst%0d: got %h want a5a5a5a5", i, act_rd(i, 0));
      end
      tests++;
      if (act_rd(i, 1) !== want1[i]) begin
        fails++;
        $display("FAIL basic_x31 inst%0d: got %h want %h", i, act_rd(i, 1), want1[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want [3];
    tick();
    we    = 2'b01;
    waddr = {5'd0, 5'd7};
    wdata = {32'h0, 32'h11};
    tick();
    wdata = {32'h0, 32'h22};
    raddr = {5'd0, 5'd7};
    want  = '{32'h22, 32'h11, 32'h22};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 0) !== want[i]) begin
        fails++;
        $display("FAIL bypass_cyc1 inst%0d: got %h want %h", i, act_rd(i, 0), want[i]);
      end
    end
    tick();
    idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 0) !== 32'h22) begin
        fails++;
        $display("FAIL bypass_cyc2 inst%0d: got %h want 22", i, act_rd(i, 0));
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] want [3];
    tick();
    we    = 2'b11;
    waddr = {5'd3, 5'd3};
    wdata = {32'h200, 32'h100};
    raddr = {5'd3, 5'd3};
    want  = '{32'h100, 32'h0, 32'h200};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 0) !== want[i]) begin
        fails++;
        $display("FAIL collision_same_cyc inst%0d: got %h want %h", i, act_rd(i, 0), want[i]);
      end
    end
    tick();
    idle();
    want = '{32'h100, 32'h200, 32'h200};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_rd(i, 1) !== want[i]) begin
        fails++;
        $display("FAIL collision_stored inst%0d: got %h want %h", i, act_rd(i, 1), want[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] want20 [3];
    tick();
    we    = 2'b01;
    waddr = {5'd0, 5'd4};
    wdata = {32'h0, 32'h77};
    tick();
    waddr = {5'd0, 5'd20};
    wdata = {32'h0, 32'h55};
    raddr = {5'd4, 5'd20};
    want20 = '{32'h55, 32'h0, 32'h0};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (act_rd(i, 0) !== want20[i]) begin
          fails++;
          $display("FAIL oor_x20 inst%0d cyc%0d: got %h want %h", i, c, act_rd(i, 0), want20[i]);
        end
        tests++;
        if (act_rd(i, 1) !== 32'h77) begin
          fails++;
          $display("FAIL oor_x4_alias inst%0d cyc%0d: got %h want 77", i, c, act_rd(i, 1));
        end
      end
      tick();
      idle();
    end
  endtask

`ifdef RF_SCOREBOARD_EN
  task automatic test_scoreboard();
    logic [1:0] want [4];
    want  = '{2'b00, 2'b11, 2'b11, 2'b00};
    raddr = {5'd9, 5'd9};
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        iv    = 2'b01;
        iaddr = {5'd0, 5'd9};
      end
      if (c == 2) begin
        we    = 2'b01;
        waddr = {5'd0, 5'd9};
        wdata = {32'h0, 32'h99};
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (act_busy(i) !== want[c]) begin
          fails++;
          $display("FAIL busy_seq inst%0d cyc%0d: got %b want %b", i, c, act_busy(i), want[c]);
        end
      end
      tick();
      idle();
    end
    iv    = 2'b01;
    iaddr = {5'd0, 5'd9};
    we    = 2'b01;
    waddr = {5'd0, 5'd9};
    wdata = {32'h0, 32'h9A};
    tick();
    idle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (act_busy(i) !== 2'b11) begin
        fails++;
        $display("FAIL busy_issue_and_wb inst%0d: got %b want 11", i, act_busy(i));
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      raddr = 10'($urandom);
      we    = 2'($urandom);
      waddr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) waddr[9:5] = waddr[4:0];
      wdata = {$urandom, $urandom};
`ifdef RF_SCOREBOARD_EN
      iv    = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      iaddr = 10'($urandom);
`endif
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (act_rd(i, k) !== exp_rd(i, k)) begin
            fails++;
            $display("FAIL rand_rd inst%0d port%0d cyc%0d: got %h want %h", i, k, c, act_rd(i, k), exp_rd(i, k));
          end
`ifdef RF_SCOREBOARD_EN
          tests++;
          if (act_busy(i)[k] !== exp_busy(i, k)) begin
            fails++;
            $display("FAIL rand_busy inst%0d port%0d cyc%0d: got %b want %b", i, k, c, act_busy(i)[k], exp_busy(i, k));
          end
`endif
        end
      end
    end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_collision();
    test_out_of_range();
`ifdef RF_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
